// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the bit-serial ALU: operands and opcode in,
// busy/done strobes with result and N/Z/V/C flags out.
interface serial_alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cntrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, a, b, cntrl,
        input  busy, done, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  start, a, b, cntrl,
        output busy, done, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one 1-bit cell evaluated LSB first, carry chained through a
// flip-flop, result collected in a right-shifting register.
module serial_alu_cell (
    input  logic [2:0] op,
    input  logic       ai,
    input  logic       bi,
    input  logic       cin,
    output logic       s,
    output logic       cout
);
    logic bx;

    // Subtract is A + ~B + 1; the +1 comes from the preloaded carry.
    assign bx   = bi ^ (op == 3'b011);
    assign cout = (ai & bx) | (ai & cin) | (bx & cin);

    always_comb begin
        s = 1'b0;
        case (op)
            3'b000:         s = bi;
            3'b010, 3'b011: s = ai ^ bx ^ cin;
            3'b100:         s = ai & bi;
            3'b101:         s = ai | bi;
            3'b110:         s = ai ^ bi;
            default:        s = 1'b0;
        endcase
    end
endmodule

module serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    serial_alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sra, srb, result_sr;
    logic [2:0]       op;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             s, cout, addsub;
    logic [WIDTH-1:0] next_sr;

    logic             busy_q, done_q, neg_q, zero_q, ovf_q, cy_out_q;
    logic [WIDTH-1:0] result_q;

    serial_alu_cell u_cell (
        .op  (op),
        .ai  (sra[0]),
        .bi  (srb[0]),
        .cin (cy),
        .s   (s),
        .cout(cout)
    );

    assign addsub  = (op == 3'b010) || (op == 3'b011);
    assign next_sr = {s, result_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sra       <= '0;
            srb       <= '0;
            op        <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            result_sr <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cy_out_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sra    <= bus.a;
                        srb    <= bus.b;
                        op     <= bus.cntrl;
                        cnt    <= '0;
                        cy     <= (bus.cntrl == 3'b011);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sra       <= {1'b0, sra[WIDTH-1:1]};
                    srb       <= {1'b0, srb[WIDTH-1:1]};
                    result_sr <= next_sr;
                    cnt       <= cnt + CW'(1);
                    if (addsub) cy <= cout;
                    if (cnt == LAST) begin
                        // cy here is the carry into the MSB; V = carry-in ^ carry-out.
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= next_sr;
                        neg_q    <= s;
                        zero_q   <= ~|next_sr;
                        cy_out_q <= addsub & cout;
                        ovf_q    <= addsub & (cy ^ cout);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cy_out_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq at WIDTH=8 and WIDTH=64.
module tb_serial_alu_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_alu_seq_if #(.WIDTH(8))  if8 ();
    serial_alu_seq_if #(.WIDTH(64)) if64 ();

    serial_alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
    serial_alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

    typedef struct {
        logic [63:0] r;
        logic        n, z, v, c;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    int cyc = 0;
    int ncmp = 0;
    int nerr = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on masked integers.
    function automatic exp_t model(int w, logic [2:0] op, logic [63:0] a_in, logic [63:0] b_in);
        exp_t e;
        logic [63:0] mask, a, b;
        logic [64:0] full;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        e.r = '0; e.v = 1'b0; e.c = 1'b0; e.acc = 0;
        case (op)
            3'b000: e.r = b;
            3'b010: begin
                full = {1'b0, a} + {1'b0, b};
                e.r = full[63:0] & mask;
                e.c = full[w];
                e.v = (a[w-1] == b[w-1]) && (e.r[w-1] != a[w-1]);
            end
            3'b011: begin
                full = {1'b0, a} + {1'b0, (~b & mask)} + 65'd1;
                e.r = full[63:0] & mask;
                e.c = full[w];
                e.v = (a[w-1] != b[w-1]) && (e.r[w-1] != a[w-1]);
            end
            3'b100: e.r = a & b;
            3'b101: e.r = a | b;
            3'b110: e.r = a ^ b;
            default: e.r = '0;
        endcase
        e.n = e.r[w-1];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    task automatic score(string tag, int w, exp_t e, logic [63:0] r,
                         logic n, logic z, logic v, logic c);
        chk({tag, " result"}, r, e.r);
        chk({tag, " N"}, 64'(n), 64'(e.n));
        chk({tag, " Z"}, 64'(z), 64'(e.z));
        chk({tag, " V"}, 64'(v), 64'(e.v));
        chk({tag, " C"}, 64'(c), 64'(e.c));
        // done is sampled by the consumer on the edge after it rises
        chk({tag, " latency"}, 64'(cyc + 1 - e.acc), 64'(w + 1));
    endtask

    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL w8 unexpected done: got done=1 expected no done");
            end else
                score("w8", 8, q8.pop_front(), {56'd0, if8.result},
                      if8.negative, if8.zero, if8.overflow, if8.carry_out);
        end
        if (if64.done === 1'b1) begin
            if (q64.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL w64 unexpected done: got done=1 expected no done");
            end else
                score("w64", 64, q64.pop_front(), if64.result,
                      if64.negative, if64.zero, if64.overflow, if64.carry_out);
        end
    end

    task automatic set_in(int w, logic s, logic [2:0] op, logic [63:0] a, logic [63:0] b);
        if (w == 8) begin
            if8.start = s; if8.cntrl = op; if8.a = a[7:0]; if8.b = b[7:0];
        end else begin
            if64.start = s; if64.cntrl = op; if64.a = a; if64.b = b;
        end
    endtask

    task automatic push(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
        exp_t e;
        e = model(w, op, a, b);
        e.acc = cyc;
        if (w == 8) q8.push_back(e); else q64.push_back(e);
    endtask

    // Drive start for one edge; optionally record the expected response.
    task automatic issue(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b, bit rec);
        @(negedge clk);
        set_in(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, op, a, b);
        if (rec) push(w, op, a, b);
    endtask

    task automatic run(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
        issue(w, op, a, b, 1'b1);
        repeat (w + 2) @(negedge clk);
    endtask

    initial begin
        logic [63:0] ra, rb;
        set_in(8, 1'b0, 3'b000, '0, '0);
        set_in(64, 1'b0, 3'b000, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy8", 64'(if8.busy), 64'd0);
        chk("reset done8", 64'(if8.done), 64'd0);
        chk("reset result8", 64'(if8.result), 64'd0);
        chk("reset flags8", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'd0);
        chk("reset result64", if64.result, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run(8, 3'b010, 64'h7F, 64'h01);
        run(8, 3'b011, 64'h05, 64'h05);
        run(8, 3'b011, 64'h00, 64'h01);
        run(8, 3'b100, 64'hF0, 64'h3C);
        run(8, 3'b101, 64'hF0, 64'h0F);
        run(8, 3'b110, 64'hAA, 64'hAA);
        run(8, 3'b000, 64'h00, 64'h5A);
        run(8, 3'b001, 64'hFF, 64'hFF);
        run(8, 3'b111, 64'h13, 64'h77);

        // start pulsed mid-RUN must be ignored
        issue(8, 3'b010, 64'd10, 64'd20, 1'b1);
        repeat (3) @(negedge clk);
        set_in(8, 1'b1, 3'b010, 64'd99, 64'd1);
        @(negedge clk);
        set_in(8, 1'b0, 3'b010, 64'd99, 64'd1);
        repeat (8) @(negedge clk);

        // async reset while bit 4 is in flight
        issue(8, 3'b010, 64'd50, 64'd60, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrun reset busy8", 64'(if8.busy), 64'd0);
        chk("midrun reset done8", 64'(if8.done), 64'd0);
        chk("midrun reset result8", 64'(if8.result), 64'd0);
        chk("midrun reset flags8", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        run(8, 3'b010, 64'd3, 64'd4);

        for (int i = 0; i < 40; i++)
            run(8, 3'($urandom_range(0, 7)), 64'($urandom), 64'($urandom));

        // WIDTH=64 wrap-around add, then back-to-back with start held high
        issue(64, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        if64.start = 1'b1;
        repeat (65) @(negedge clk);
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        set_in(64, 1'b1, 3'b011, ra, rb);
        @(posedge clk);
        #1;
        chk("b2b busy64", 64'(if64.busy), 64'd1);
        chk("b2b done64 one cycle", 64'(if64.done), 64'd0);
        push(64, 3'b011, ra, rb);
        set_in(64, 1'b0, 3'b011, ra, rb);
        repeat (66) @(negedge clk);

        for (int i = 0; i < 10; i++)
            run(64, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});

        repeat (5) @(negedge clk);
        chk("q8 drained", 64'(q8.size()), 64'd0);
        chk("q64 drained", 64'(q64.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
Bit-serial ALU sequencer for the ARM datapath's low-area execute option. It latches two WIDTH-bit operands and a 3-bit ALU control code, then evaluates one bit per clock, LSB first, through a single 1-bit ALU cell. A carry flip-flop chains the bits, and a shift register collects the result. When the pass completes, it presents the full result plus N/Z/V/C flags to the flag register and writeback.

Parameters:
WIDTH, 64, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
start  input  1  request a new operation; sampled only when not busy.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
cntrl  input  3  operation code; sampled with start.
busy  output  1  high while bits are being evaluated.
done  output  1  one-cycle pulse when result and flags become valid.
result  output  WIDTH  completed result; holds until the next accepted start.
negative  output  1  N flag, equal to result[WIDTH-1].
zero  output  1  Z flag, 1 when result == 0.
overflow  output  1  V flag; add/sub only, 0 otherwise.
carry_out  output  1  C flag; add/sub only, 0 otherwise.

Behaviour:
- cntrl encoding:
  - 000 pass B.
  - 010 A+B.
  - 011 A-B, computed as A + ~B + 1.
  - 100 AND, 101 OR, 110 XOR.
  - 001 and 111 are reserved: each result bit is 0, V=0, C=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: one cycle, busy=0, done=1.
- Start acceptance: start=1 in IDLE or DONE is accepted at that edge.
  - Latch a, b, cntrl.
  - Clear bit counter to 0.
  - Load carry flip-flop with 1 for 011, else 0.
  - Go to RUN.
- start is ignored while in RUN; latched operands stay unchanged.
- RUN, each edge:
  - Evaluate bit i = counter using A[i], B[i] (inverted for 011) and the carry flip-flop.
  - Shift the bit into result_sr at the MSB while shifting right.
  - Update the carry flip-flop (add/sub only).
  - Increment counter.
  - On the edge processing i = WIDTH-1, capture the carry into the MSB as cmsb, then go to DONE.
- Latency:
  - Start accepted at edge k.
  - Bits processed at edges k+1 .. k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after the start edge.
- DONE:
  - Drive result = result_sr.
  - Flags are registered at the DONE transition: N = MSB, Z = ~|result, C = final carry, V = cmsb ^ final carry.
  - Return to IDLE next edge unless start=1.
- result and flags remain stable in IDLE until the next accepted start completes.
  - They do not change during RUN.
- Counter width: clog2(WIDTH)+1 bits; no wrap occurs because the state leaves RUN at WIDTH-1.
- Reset (any time, including mid-RUN):
  - State IDLE; busy=0, done=0.
  - result=0, all flags 0, counter=0, carry flip-flop=0.
  - The in-flight operation is discarded, and no done pulse follows deassertion.
- start held high continuously: back-to-back operations with exactly one DONE cycle between RUN phases.

Test Plan:
1. WIDTH=8, add a=8'h7F b=8'h01 -> busy for 8 cycles; done at edge 9 after start; result=8'h80, N=1, Z=0, V=1, C=0.
2. WIDTH=8, sub a=8'h05 b=8'h05 -> result=8'h00, Z=1, C=1, V=0, N=0. Then sub a=8'h00 b=8'h01 -> result=8'hFF, N=1, C=0, V=0.
3. WIDTH=8 logic ops:
   - AND F0/3C -> 8'h30.
   - OR F0/0F -> 8'hFF, N=1.
   - XOR AA/AA -> 8'h00, Z=1, V=0, C=0.
   - pass B with b=8'h5A -> 8'h5A.
   - reserved 001 -> 8'h00, Z=1.
4. WIDTH=8, start add 10+20; pulse start with a=99 b=1 during RUN -> ignored, result=8'd30, exactly one done pulse.
5. WIDTH=8, start add; drop reset low at bit 4 -> busy, done, result, flags go 0 immediately. After release, no done appears until a new start; new add 3+4 -> 8'd7.
6. WIDTH=64, add 64'hFFFF_FFFF_FFFF_FFFF + 1 -> result=0, Z=1, C=1, V=0; done exactly 65 edges after start. Hold start high -> DONE lasts one cycle and a second op begins immediately.
